// File: rtl/sqrt_share_arbiter.sv
// sqrt_share_arbiter: round-robin sharing of one square_root unit among NUM_REQ requesters.
// Optional SQRT_ARB_ZERO_BYPASS_EN: zero radicands are answered without starting the unit.
module sqrt_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] rad_in,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        res_valid,
    output logic [DATA_W-1:0]         res_root,
    output logic                      busy,
    output logic                      sq_start,
    output logic [DATA_W-1:0]         sq_rad,
    input  logic [DATA_W-1:0]         sq_root,
    input  logic                      sq_done
);
    localparam int IW = $clog2(NUM_REQ);
    localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};
`ifdef SQRT_ARB_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [IW-1:0] owner, last, pick, idx;
    logic [DATA_W-1:0] pick_rad;
    logic zero_job, pick_zero, accept, start_n;
    logic [NUM_REQ-1:0] gnt_n, valid_n;
    // Walk downwards so the nearest requester after last overwrites the others.
    always_comb begin
        pick = last;
        idx = last;
        for (int k = NUM_REQ; k > 0; k--) begin
            idx = IW'((int'(last) + k) % NUM_REQ);
            if (req[idx]) pick = idx;
        end
    end
    assign pick_rad = rad_in[pick*DATA_W +: DATA_W];
    assign pick_zero = BYPASS && (pick_rad == '0);
    assign accept = (state == IDLE) && (|req);
    always_comb begin
        state_n = state;
        gnt_n = '0;
        valid_n = '0;
        start_n = 1'b0;
        case (state)
            IDLE: begin
                state_n = accept ? ISSUE : IDLE;
                gnt_n = accept ? (ONE << pick) : '0;
                start_n = accept && !pick_zero;
            end
            ISSUE: begin
                state_n = zero_job ? RESP : WAIT;
                valid_n = zero_job ? (ONE << owner) : '0;
            end
            WAIT: begin
                state_n = sq_done ? RESP : WAIT;
                valid_n = sq_done ? (ONE << owner) : '0;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= '0;
            last <= IW'(NUM_REQ - 1);
            zero_job <= 1'b0;
            gnt <= '0;
            res_valid <= '0;
            res_root <= '0;
            busy <= 1'b0;
            sq_start <= 1'b0;
            sq_rad <= '0;
        end else begin
            state <= state_n;
            gnt <= gnt_n;
            res_valid <= valid_n;
            sq_start <= start_n;
            busy <= state_n != IDLE;
            if (accept) begin
                owner <= pick;
                last <= pick;
                sq_rad <= pick_rad;
                zero_job <= pick_zero;
            end
            if (state == WAIT && sq_done) res_root <= sq_root;
            if (state == ISSUE && zero_job) res_root <= '0;
        end
    end
endmodule

// File: tb/tb_sqrt_share_arbiter.sv
// tb_sqrt_share_arbiter: directed bench with a square_root stub (root = ~rad, latency lat).
module tb_sqrt_share_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic [3:0] req = '0;
    logic [127:0] rad_in = '0;
    logic [3:0] gnt, res_valid;
    logic [31:0] res_root, sq_rad, sq_root, srad = '0;
    logic busy, sq_start, sq_done, force_done = 1'b0;
    int cnt = 0;
    int lat = 29;
    int total = 0;
    int bad = 0;
    sqrt_share_arbiter #(.NUM_REQ(4), .DATA_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .rad_in(rad_in), .gnt(gnt),
        .res_valid(res_valid), .res_root(res_root), .busy(busy), .sq_start(sq_start),
        .sq_rad(sq_rad), .sq_root(sq_root), .sq_done(sq_done)
    );
    always #5 clk = ~clk;
    // Stub deliberately ignores reset so a late done can arrive after a mid-job reset.
    always @(posedge clk) begin
        if (sq_start) begin
            cnt <= lat;
            srad <= sq_rad;
        end else if (cnt != 0) cnt <= cnt - 1;
    end
    assign sq_done = (cnt == 1) || force_done;
    assign sq_root = ~srad;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic do_reset();
        reset_n = 1'b0;
        req = '0;
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask
    task automatic wait_gnt(output logic [3:0] g);
        int n = 0;
        do begin cyc(1); n++; end while (gnt == '0 && n < 40);
        g = gnt;
        if (gnt == '0) chk("gnt_timeout", 32'd0, 32'd1);
    endtask
    task automatic wait_res(output logic [3:0] v);
        int n = 0;
        do begin cyc(1); n++; end while (res_valid == '0 && n < 40);
        v = res_valid;
        if (res_valid == '0) chk("res_timeout", 32'd0, 32'd1);
    endtask
    logic [31:0] rads [4] = '{32'h0000_1111, 32'h0000_2222, 32'h0003_3333, 32'h4444_0000};
    logic [3:0] g, v, seen;
    int order2 [4] = '{0, 1, 2, 3};
    int order3 [4] = '{0, 2, 0, 2};
    initial begin
        cyc(1);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_valid", 32'(res_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(sq_start), 0);
        chk("rst_rad", sq_rad, 0);
        chk("rst_root", res_root, 0);
        reset_n = 1'b1;
        cyc(1);
        // 1: single job, exact latency
        req = 4'b0001;
        rad_in[31:0] = 32'h90;
        cyc(1);
        chk("t1_gnt", 32'(gnt), 32'h1);
        chk("t1_start", 32'(sq_start), 1);
        chk("t1_rad", sq_rad, 32'h90);
        chk("t1_busy", 32'(busy), 1);
        req = '0;
        cyc(1);
        chk("t1_gnt_pulse", 32'(gnt), 0);
        chk("t1_start_pulse", 32'(sq_start), 0);
        cyc(28);
        chk("t1_early_valid", 32'(res_valid), 0);
        cyc(1);
        chk("t1_valid", 32'(res_valid), 32'h1);
        chk("t1_root", res_root, 32'hFFFF_FF6F);
        chk("t1_busy_resp", 32'(busy), 1);
        cyc(1);
        chk("t1_valid_pulse", 32'(res_valid), 0);
        chk("t1_busy_low", 32'(busy), 0);
        // 2: all four request, each drops after its grant
        do_reset();
        for (int i = 0; i < 4; i++) rad_in[i*32 +: 32] = rads[i];
        req = 4'b1111;
        for (int j = 0; j < 4; j++) begin
            wait_gnt(g);
            chk("t2_gnt", 32'(g), 32'(4'b0001 << order2[j]));
            chk("t2_rad", sq_rad, rads[order2[j]]);
            req = req & ~g;
            wait_res(v);
            chk("t2_valid", 32'(v), 32'(g));
            chk("t2_root", res_root, ~rads[order2[j]]);
        end
        // 3: req0 and req2 held continuously
        do_reset();
        req = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            wait_gnt(g);
            chk("t3_gnt", 32'(g), 32'(4'b0001 << order3[j]));
            wait_res(v);
            chk("t3_valid", 32'(v), 32'(g));
            chk("t3_root", res_root, ~rads[order3[j]]);
        end
        req = '0;
        cyc(3);
        // 4: reset in WAIT, late done must be ignored
        do_reset();
        req = 4'b0001;
        wait_gnt(g);
        req = '0;
        cyc(5);
        reset_n = 1'b0;
        #1;
        chk("t4_rst_out", {gnt, res_valid, 7'd0, busy, sq_start, 14'd0}, 0);
        chk("t4_rst_rad", sq_rad, 0);
        chk("t4_rst_root", res_root, 0);
        cyc(2);
        reset_n = 1'b1;
        seen = '0;
        for (int n = 0; n < 30; n++) begin
            cyc(1);
            seen = seen | res_valid;
        end
        chk("t4_late_done", 32'(seen), 0);
        req = 4'b0010;
        wait_gnt(g);
        chk("t4_gnt", 32'(g), 32'h2);
        req = '0;
        wait_res(v);
        chk("t4_valid", 32'(v), 32'h2);
        chk("t4_root", res_root, ~rads[1]);
        cyc(2);
        // 5: stray done while idle
        force_done = 1'b1;
        cyc(1);
        force_done = 1'b0;
        seen = '0;
        for (int n = 0; n < 3; n++) begin
            cyc(1);
            seen = seen | res_valid;
        end
        chk("t5_valid", 32'(seen), 0);
        chk("t5_root", res_root, ~rads[1]);
        chk("t5_busy", 32'(busy), 0);
        // 6: zero radicand
        do_reset();
        rad_in[31:0] = '0;
        req = 4'b0001;
        cyc(1);
        chk("t6_gnt", 32'(gnt), 32'h1);
        req = '0;
`ifdef SQRT_ARB_ZERO_BYPASS_EN
        chk("t6_start", 32'(sq_start), 0);
        cyc(1);
        chk("t6_valid", 32'(res_valid), 32'h1);
        chk("t6_root", res_root, 32'h0);
`else
        chk("t6_start", 32'(sq_start), 1);
        cyc(29);
        chk("t6_early_valid", 32'(res_valid), 0);
        cyc(1);
        chk("t6_valid", 32'(res_valid), 32'h1);
        chk("t6_root", res_root, 32'hFFFF_FFFF);
`endif
        cyc(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
